imem_responder: RTL and testbench

IMEM_RESPONDER -- requirements
Module: imem_responder

---
 rtl/imem_responder.sv | 153 +++++++++++++++
 tb/tb_imem_responder.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/imem_responder.sv
// imem_responder: instruction-memory fetch responder with a fixed, parameterised latency.
//
// A fetch request (req_valid/req_ready) is accepted only in IDLE. After LATENCY wait
// cycles the instruction word is captured into the response registers and presented
// on rsp_* until the consumer takes it (rsp_ready) or a flush abandons it. A separate
// load port (ld_*) writes program words at any time. Memory contents survive reset.
//
// Ports
//   clk        : single clock, rising edge
//   reset      : synchronous, active-low reset
//   req_valid  : fetch request present
//   req_ready  : request can be accepted this cycle
//   req_addr   : word index of requested instruction
//   flush      : abandon any in-flight request
//   rsp_valid  : response present
//   rsp_ready  : consumer accepts the response this cycle
//   rsp_data   : instruction word (0 when out of range)
//   rsp_addr   : address of the returned instruction
//   rsp_err    : requested address was out of range
//   ld_en      : program-load write strobe
//   ld_addr    : program-load word address (out of range is ignored)
//   ld_data    : program-load data
module imem_responder #(
    parameter int unsigned WORD    = 32,
    parameter int unsigned SIZE    = 1024,
    parameter int unsigned LATENCY = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [WORD-1:0] req_addr,
    input  logic            flush,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [WORD-1:0] rsp_data,
    output logic [WORD-1:0] rsp_addr,
    output logic            rsp_err,
    input  logic            ld_en,
    input  logic [WORD-1:0] ld_addr,
    input  logic [WORD-1:0] ld_data
);

    localparam int unsigned    AW      = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam logic [3:0]      CntInit = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);
    localparam logic [WORD-1:0] SizeW   = WORD'(SIZE);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [WORD-1:0] addr_q, addr_d;
    logic [WORD-1:0] rsp_data_q;
    logic [WORD-1:0] rsp_addr_q;
    logic            rsp_err_q;

    logic            accept;
    logic            capture;
    logic [WORD-1:0] cap_addr;
    logic            cap_in_range;
    logic            ld_in_range;

    logic [WORD-1:0] mem [SIZE];

    // With LATENCY=0 the read is captured on the accept edge itself, so the address comes
    // straight from the request port rather than the latched copy.
    assign cap_addr     = (state_q == StIdle) ? req_addr : addr_q;
    assign cap_in_range = (cap_addr < SizeW);
    assign ld_in_range  = (ld_addr < SizeW);
    assign accept       = req_valid && req_ready;

    // Program-load write port; no reset so contents survive it.
    always_ff @(posedge clk) begin
        if (ld_en && ld_in_range) begin
            mem[ld_addr[AW-1:0]] <= ld_data;
        end
    end

    // State register plus response registers. The memory read here sees the value
    // before any same-edge load write, so a colliding load does not leak into the response.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= StIdle;
            cnt_q      <= 4'd0;
            addr_q     <= '0;
            rsp_data_q <= '0;
            rsp_addr_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            if (capture) begin
                rsp_data_q <= cap_in_range ? mem[cap_addr[AW-1:0]] : '0;
                rsp_addr_q <= cap_addr;
                rsp_err_q  <= !cap_in_range;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        capture = 1'b0;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    addr_d = req_addr;
                    if (LATENCY == 0) begin
                        state_d = StResp;
                        capture = 1'b1;
                    end else begin
                        state_d = StWait;
                        cnt_d   = CntInit;
                    end
                end
            end
            StWait: begin
                if (flush) begin
                    state_d = StIdle;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'd0) begin
                    state_d = StResp;
                    capture = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                // Flush wins over a simultaneous consumer accept.
                if (flush || rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Outputs.
    always_comb begin
        req_ready = reset && (state_q == StIdle) && !flush;
        rsp_valid = (state_q == StResp);
        rsp_data  = rsp_data_q;
        rsp_addr  = rsp_addr_q;
        rsp_err   = rsp_err_q;
    end

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: a LATENCY=2 and a LATENCY=0 instance share all inputs and are
// each compared every cycle against a transaction-level model (pending request + due edge).
module tb_imem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        flush;
    logic        rsp_ready;
    logic        ld_en;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;

    logic        d_ready [2];
    logic        d_valid [2];
    logic [31:0] d_data  [2];
    logic [31:0] d_addr  [2];
    logic        d_err   [2];

    always #5 clk = ~clk;

    imem_responder #(.WORD(32), .SIZE(1024), .LATENCY(2)) u_lat2 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(d_ready[0]),
        .req_addr(req_addr), .flush(flush), .rsp_valid(d_valid[0]), .rsp_ready(rsp_ready),
        .rsp_data(d_data[0]), .rsp_addr(d_addr[0]), .rsp_err(d_err[0]), .ld_en(ld_en),
        .ld_addr(ld_addr), .ld_data(ld_data)
    );

    imem_responder #(.WORD(32), .SIZE(1024), .LATENCY(0)) u_lat0 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(d_ready[1]),
        .req_addr(req_addr), .flush(flush), .rsp_valid(d_valid[1]), .rsp_ready(rsp_ready),
        .rsp_data(d_data[1]), .rsp_addr(d_addr[1]), .rsp_err(d_err[1]), .ld_en(ld_en),
        .ld_addr(ld_addr), .ld_data(ld_data)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a request is pending from accept until completion; its word is
    // read (pre-load) at edge accept+LATENCY and is visible from then until taken.
    int unsigned lat [2] = '{2, 0};
    bit          m_busy  [2] = '{0, 0};
    bit          m_cap   [2] = '{0, 0};
    bit          m_fresh [2] = '{0, 0};
    int          m_due   [2];
    logic [31:0] m_req   [2];
    logic [31:0] m_data  [2];
    logic [31:0] m_raddr [2];
    logic        m_err   [2];
    logic [31:0] m_mem   [16];
    int          cyc   = 0;
    bit          armed = 0;

    function automatic bit exp_ready(input int i);
        return reset && !m_busy[i] && !flush;
    endfunction

    task automatic model_edge();
        bit rdy [2];
        for (int i = 0; i < 2; i++) rdy[i] = exp_ready(i);
        for (int i = 0; i < 2; i++) begin
            if (!reset) begin
                m_busy[i] = 0; m_cap[i] = 0; m_fresh[i] = 1;
                m_data[i] = '0; m_raddr[i] = '0; m_err[i] = 1'b0;
            end else if (m_busy[i]) begin
                if (flush || (m_cap[i] && rsp_ready)) begin
                    m_busy[i] = 0; m_cap[i] = 0;
                end
            end else if (req_valid && rdy[i]) begin
                m_busy[i] = 1; m_cap[i] = 0; m_req[i] = req_addr; m_due[i] = cyc + int'(lat[i]);
            end
            if (m_busy[i] && !m_cap[i] && cyc == m_due[i]) begin
                m_cap[i]   = 1;
                m_fresh[i] = 0;
                m_raddr[i] = m_req[i];
                m_err[i]   = (m_req[i] >= 32'd1024);
                m_data[i]  = m_err[i] ? 32'd0 : m_mem[m_req[i][3:0]];
            end
        end
        if (ld_en && ld_addr < 32'd1024) m_mem[ld_addr[3:0]] = ld_data;
        if (!reset) armed = 1;
        cyc++;
    endtask

    task automatic tick();
        #1;
        if (armed) begin
            for (int i = 0; i < 2; i++) begin
                check_eq($sformatf("lat%0d_req_ready", lat[i]), 32'(d_ready[i]),
                         32'(exp_ready(i)));
                check_eq($sformatf("lat%0d_rsp_valid", lat[i]), 32'(d_valid[i]),
                         32'(m_busy[i] && m_cap[i]));
                if ((m_busy[i] && m_cap[i]) || m_fresh[i]) begin
                    check_eq($sformatf("lat%0d_rsp_data", lat[i]), d_data[i], m_data[i]);
                    check_eq($sformatf("lat%0d_rsp_addr", lat[i]), d_addr[i], m_raddr[i]);
                    check_eq($sformatf("lat%0d_rsp_err", lat[i]), 32'(d_err[i]),
                             32'(m_err[i]));
                end
            end
        end
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    initial begin
        int n_rsp;
        reset = 1'b0; req_valid = 1'b0; req_addr = '0; flush = 1'b0; rsp_ready = 1'b0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        @(negedge clk);
        repeat (3) tick();
        reset = 1'b1;

        // Program load, plus out-of-range writes that would alias words 0 and 5.
        ld_en = 1'b1;
        for (int k = 0; k < 16; k++) begin
            ld_addr = 32'(k);
            ld_data = (k == 5) ? 32'h2002000A : $urandom;
            tick();
        end
        ld_addr = 32'd1024; ld_data = 32'hDEADBEEF; tick();
        ld_addr = 32'd1029; ld_data = 32'hBAD0BAD0; tick();
        ld_en = 1'b0;

        // Fetch word 5, hold it back for a while, then take it.
        req_valid = 1'b1; req_addr = 32'd5; rsp_ready = 1'b0; tick();
        req_valid = 1'b0;
        tick(); tick();
        check_eq("lat2_first_valid", 32'(d_valid[0]), 32'd1);
        check_eq("lat2_first_data", d_data[0], 32'h2002000A);
        check_eq("lat2_first_addr", d_addr[0], 32'd5);
        repeat (4) tick();
        check_eq("lat2_hold_data", d_data[0], 32'h2002000A);
        check_eq("lat2_hold_valid", 32'(d_valid[0]), 32'd1);
        rsp_ready = 1'b1; tick();
        rsp_ready = 1'b0; tick();

        // Out-of-range fetch.
        req_valid = 1'b1; req_addr = 32'd1024; tick();
        req_valid = 1'b0; rsp_ready = 1'b1;
        repeat (4) tick();

        // Flush an in-flight fetch, then fetch another.
        req_valid = 1'b1; req_addr = 32'd7; tick();
        req_valid = 1'b0; flush = 1'b1; tick();
        flush = 1'b0; tick();
        req_valid = 1'b1; req_addr = 32'd9; tick();
        req_valid = 1'b0;
        repeat (4) tick();

        // Back-to-back fetches with the consumer always ready.
        n_rsp = 0;
        for (int k = 0; k < 12; k++) begin
            req_valid = 1'b1;
            req_addr  = 32'($urandom_range(0, 15));
            if (d_valid[1]) n_rsp++;
            tick();
        end
        req_valid = 1'b0;
        check_eq("lat0_b2b_count", 32'(n_rsp), 32'd6);
        repeat (4) tick();

        // Reset while a response is waiting.
        req_valid = 1'b1; req_addr = 32'd3; rsp_ready = 1'b0; tick();
        req_valid = 1'b0;
        repeat (3) tick();
        reset = 1'b0; tick();
        reset = 1'b1;
        check_eq("reset_drop_valid", 32'(d_valid[0]), 32'd0);
        check_eq("reset_drop_data", d_data[0], 32'd0);
        tick();
        req_valid = 1'b1; req_addr = 32'd3; rsp_ready = 1'b1; tick();
        req_valid = 1'b0;
        repeat (4) tick();

        // Randomised traffic.
        for (int k = 0; k < 3000; k++) begin
            reset     = ($urandom_range(0, 99) != 0);
            flush     = ($urandom_range(0, 9) == 0);
            req_valid = 1'($urandom_range(0, 1));
            req_addr  = ($urandom_range(0, 5) == 0) ? 32'(1024 + $urandom_range(0, 15))
                                                    : 32'($urandom_range(0, 15));
            rsp_ready = ($urandom_range(0, 2) != 0);
            ld_en     = ($urandom_range(0, 3) == 0);
            ld_addr   = 32'($urandom_range(0, 15)) +
                        (($urandom_range(0, 3) == 0) ? 32'd1024 : 32'd0);
            ld_data   = $urandom;
            tick();
        end
        reset = 1'b1; flush = 1'b0; req_valid = 1'b0; ld_en = 1'b0; rsp_ready = 1'b1;
        repeat (5) tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
